core_seq_ctrl: RTL and testbench

Multi-cycle sequencer for the 32-bit, 8-register core ISA. It sequences fetch, decode, execute, memory and writeback over a single shared memory port. It drives the register-file read/write ports and the ALU operation select, and owns the PC and the instruction register. It sits between the unified memory interface and the register file/ALU datapath, and makes the datapath a multi-cycle processor that shares one memory for instructions and data.

---
 rtl/core_seq_ctrl.sv | 103 ++++++++++
 tb/tb_core_seq_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: multi-cycle fetch/decode/exec/mem/wb sequencer over one shared memory port
// Ports: clk, rst_n (async active-low) ; i_en run enable sampled in IDLE and at retire
//   o_mem_req/o_mem_we/o_mem_addr/o_mem_wdata, i_mem_rdata/i_mem_ready : unified memory port
//   o_rf_raddr1/o_rf_raddr2, i_rf_rdata1/i_rf_rdata2, o_rf_we/o_rf_waddr/o_rf_wdata : register file
//   o_alu_op/o_alu_src_imm/o_imm_sext, i_alu_result : ALU control and result
//   o_pc, o_busy, o_retire, o_illegal_op : status
module core_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_en,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ready,
  output logic [2:0]  o_rf_raddr1,
  output logic [2:0]  o_rf_raddr2,
  input  logic [31:0] i_rf_rdata1,
  input  logic [31:0] i_rf_rdata2,
  output logic        o_rf_we,
  output logic [2:0]  o_rf_waddr,
  output logic [31:0] o_rf_wdata,
  output logic [2:0]  o_alu_op,
  output logic        o_alu_src_imm,
  output logic [31:0] o_imm_sext,
  input  logic [31:0] i_alu_result,
  output logic [31:0] o_pc,
  output logic        o_busy,
  output logic        o_retire,
  output logic        o_illegal_op
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
  localparam logic [5:0] OP_ADD = 6'd1, OP_SUB = 6'd2, OP_ADDI = 6'd3, OP_LOAD = 6'd4, OP_STORE = 6'd5;
  localparam logic [2:0] ALU_NOP = 3'd0, ALU_ADD = 3'd1, ALU_SUB = 3'd2;
  state_t      r_state, w_next;
  logic [31:0] r_pc, r_ir, r_alu_q, r_ld_q;
  logic [5:0]  w_op;
  logic        w_is_alu, w_is_load, w_is_store, w_is_mem, w_retire, w_unused;
  assign w_op       = r_ir[31:26];
  assign w_is_alu   = w_op == OP_ADD || w_op == OP_SUB || w_op == OP_ADDI;
  assign w_is_load  = w_op == OP_LOAD;
  assign w_is_store = w_op == OP_STORE;
  assign w_is_mem   = w_is_load || w_is_store;
  // NOP/illegal finish in EXEC, STORE on its accepted MEM cycle, everything else in WB
  assign w_retire   = (r_state == S_EXEC && !w_is_alu && !w_is_mem)
                   || (r_state == S_MEM && w_is_store && i_mem_ready)
                   || r_state == S_WB;
  // rs1 data feeds the external ALU directly; the low instruction bits are never decoded
  assign w_unused   = ^{i_rf_rdata1, r_ir[3:0]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    if (w_retire) w_next = i_en ? S_FETCH : S_IDLE;
    else begin
      case (r_state)
        S_IDLE:   w_next = i_en ? S_FETCH : S_IDLE;
        S_FETCH:  w_next = i_mem_ready ? S_DECODE : S_FETCH;
        S_DECODE: w_next = S_EXEC;
        S_EXEC:   w_next = w_is_alu ? S_WB : S_MEM;
        S_MEM:    w_next = i_mem_ready ? S_WB : S_MEM;
        default:  w_next = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_alu_q <= '0;
      r_ld_q  <= '0;
    end else begin
      if (r_state == S_FETCH && i_mem_ready) r_ir <= i_mem_rdata;
      if (r_state == S_EXEC) r_alu_q <= i_alu_result;
      if (r_state == S_MEM && w_is_load && i_mem_ready) r_ld_q <= i_mem_rdata;
      if (w_retire) r_pc <= r_pc + 32'd4;
    end
  end
  always_comb begin
    o_mem_req     = r_state == S_FETCH || r_state == S_MEM;
    o_mem_we      = r_state == S_MEM && w_is_store;
    o_mem_addr    = r_state == S_MEM ? r_alu_q : r_pc;
    o_mem_wdata   = r_state == S_MEM && w_is_store ? i_rf_rdata2 : 32'd0;
    o_rf_raddr1   = r_ir[22:20];
    o_rf_raddr2   = w_is_store ? r_ir[25:23] : r_ir[19:17];
    o_rf_we       = r_state == S_WB;
    o_rf_waddr    = r_ir[25:23];
    o_rf_wdata    = w_is_load ? r_ld_q : r_alu_q;
    o_alu_op      = r_state != S_EXEC ? ALU_NOP : w_op == OP_SUB ? ALU_SUB
                  : (w_is_alu || w_is_mem) ? ALU_ADD : ALU_NOP;
    o_alu_src_imm = r_state == S_EXEC && (w_op == OP_ADDI || w_is_mem);
    o_imm_sext    = {{16{r_ir[19]}}, r_ir[19:4]};
    o_pc          = r_pc;
    o_busy        = r_state != S_IDLE;
    o_retire      = w_retire;
    o_illegal_op  = r_state == S_EXEC && w_op > OP_STORE;
  end
endmodule

// File: tb/tb_core_seq_ctrl.sv
// tb_core_seq_ctrl: random and directed programs checked against an instruction-level model
module tb_core_seq_ctrl;
  logic        clk = 1'b0, rst_n = 1'b1, en = 1'b0, mem_ready = 1'b0;
  logic        mem_req, mem_we, rf_we, alu_src_imm, busy, retire, illegal_op;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, rf_rdata1, rf_rdata2, rf_wdata, imm_sext;
  logic [31:0] alu_result, alu_b, pc;
  logic [2:0]  rf_raddr1, rf_raddr2, rf_waddr, alu_op;
  logic [31:0] mem [256];
  logic [31:0] rf [8];
  logic [31:0] m_mem [256];
  logic [31:0] m_rf [8];
  logic [31:0] m_pc;
  int          n_chk = 0, n_pass = 0, n_ret = 0;
  int          n_cyc, n_wait, n_acc, n_we;
  logic [31:0] f_addr, d_addr, d_wdata, w_data, h_addr, h_wdata;
  logic [2:0]  w_addr;
  logic        d_we, h_we, held = 1'b0, pend = 1'b0, pend_en = 1'b0, mon_on = 1'b0;

  core_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .i_en(en),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .i_mem_ready(mem_ready),
    .o_rf_raddr1(rf_raddr1), .o_rf_raddr2(rf_raddr2), .i_rf_rdata1(rf_rdata1), .i_rf_rdata2(rf_rdata2),
    .o_rf_we(rf_we), .o_rf_waddr(rf_waddr), .o_rf_wdata(rf_wdata),
    .o_alu_op(alu_op), .o_alu_src_imm(alu_src_imm), .o_imm_sext(imm_sext), .i_alu_result(alu_result),
    .o_pc(pc), .o_busy(busy), .o_retire(retire), .o_illegal_op(illegal_op)
  );

  always #5 clk = ~clk;
  assign mem_rdata  = mem[mem_addr[9:2]];
  assign rf_rdata1  = rf[rf_raddr1];
  assign rf_rdata2  = rf[rf_raddr2];
  assign alu_b      = alu_src_imm ? imm_sext : rf_rdata2;
  assign alu_result = alu_op == 3'd1 ? rf_rdata1 + alu_b : alu_op == 3'd2 ? rf_rdata1 - alu_b : 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                                      input logic [15:0] imm);
    return {op, rd, rs1, imm, 4'h0};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] x;
    int          k;
    x = $urandom;
    k = $urandom_range(0, 9);
    x[31:26] = k < 6 ? 6'(k) : 6'($urandom_range(6, 63));
    return x;
  endfunction

  task automatic clr();
    n_cyc = 0; n_wait = 0; n_acc = 0; n_we = 0;
  endtask

  task automatic sync_model();
    for (int i = 0; i < 256; i++) m_mem[i] = mem[i];
    for (int i = 0; i < 8; i++) m_rf[i] = rf[i];
    m_pc = 32'd0;
    clr();
  endtask

  // One whole instruction at ISA level, compared with what the DUT did since the previous retire
  task automatic model_step();
    logic [31:0] ins, imm, ea, res;
    logic [5:0]  op;
    logic [2:0]  rd, rs1, rs2;
    logic        wr, mop;
    int          base;
    ins  = m_mem[m_pc[9:2]];
    op   = ins[31:26];
    rd   = ins[25:23];
    rs1  = ins[22:20];
    rs2  = ins[19:17];
    imm  = 32'($signed(ins[19:4]));
    ea   = m_rf[rs1] + imm;
    wr   = op >= 6'd1 && op <= 6'd4;
    mop  = op == 6'd4 || op == 6'd5;
    base = (op == 6'd0 || op > 6'd5) ? 3 : op == 6'd4 ? 5 : 4;
    res  = op == 6'd1 ? m_rf[rs1] + m_rf[rs2] : op == 6'd2 ? m_rf[rs1] - m_rf[rs2]
         : op == 6'd3 ? ea : m_mem[ea[9:2]];
    check("fetch_addr", f_addr, m_pc);
    check("pc_at_retire", pc, m_pc);
    check("cycles", 32'(n_cyc - n_wait), 32'(base));
    check("mem_accepts", 32'(n_acc), mop ? 32'd2 : 32'd1);
    check("rf_writes", 32'(n_we), 32'(wr));
    check("illegal_op", 32'(illegal_op), 32'(op > 6'd5));
    if (wr) begin
      check("rf_waddr", 32'(w_addr), 32'(rd));
      check("rf_wdata", w_data, res);
      m_rf[rd] = res;
    end
    if (mop) begin
      check("data_addr", d_addr, ea);
      check("data_we", 32'(d_we), 32'(op == 6'd5));
    end
    if (op == 6'd5) begin
      check("store_data", d_wdata, m_rf[rd]);
      m_mem[ea[9:2]] = m_rf[rd];
    end
    m_pc += 32'd4;
  endtask

  // Per-cycle observation at the falling edge, plus the bench memory/register-file writes
  task automatic mon();
    if (!rst_n) return;
    if (mon_on) begin
      if (pend) begin
        check("busy_after_retire", 32'(busy), 32'(pend_en));
        pend = 1'b0;
      end
      if (busy) n_cyc++;
      if (mem_req && !mem_ready) n_wait++;
      if (held) begin
        check("hold_req", 32'(mem_req), 32'd1);
        check("hold_addr", mem_addr, h_addr);
        check("hold_we", 32'(mem_we), 32'(h_we));
        check("hold_wdata", mem_wdata, h_wdata);
      end
      held = mem_req && !mem_ready;
      h_addr = mem_addr; h_we = mem_we; h_wdata = mem_wdata;
      if (mem_req && mem_ready) begin
        n_acc++;
        if (n_acc == 1) f_addr = mem_addr;
        else begin d_addr = mem_addr; d_we = mem_we; d_wdata = mem_wdata; end
      end
      if (rf_we) begin n_we++; w_addr = rf_waddr; w_data = rf_wdata; end
      if (illegal_op) check("illegal_needs_retire", 32'(retire), 32'd1);
      if (retire) begin
        model_step();
        n_ret++;
        pend = 1'b1;
        pend_en = en;
        clr();
      end
    end
    if (mem_req && mem_ready && mem_we) mem[mem_addr[9:2]] = mem_wdata;
    if (rf_we) rf[rf_waddr] = rf_wdata;
  endtask

  task automatic step(input logic e, input logic r);
    en = e;
    mem_ready = r;
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    for (int i = 0; i < 8; i++) rf[i] = 32'd0;
    rf[1] = 32'd7;
    rf[2] = 32'd9;
    mem[0] = enc(6'd1, 3'd3, 3'd1, {3'd2, 13'd0});
    mem[1] = enc(6'd2, 3'd4, 3'd1, {3'd2, 13'd0});
    mem[2] = enc(6'd3, 3'd1, 3'd0, 16'h0100);
    mem[3] = enc(6'd3, 3'd2, 3'd0, 16'h00AB);
    mem[4] = enc(6'd5, 3'd2, 3'd1, 16'hFFFC);
    mem[5] = enc(6'd4, 3'd5, 3'd1, 16'hFFFC);
    mem[6] = enc(6'h3F, 3'd0, 3'd0, 16'h0000);
    mem[7] = enc(6'd3, 3'd6, 3'd0, 16'h0005);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_retire", 32'(retire), 32'd0);
    check("rst_illegal", 32'(illegal_op), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_alu_src_imm", 32'(alu_src_imm), 32'd0);
    check("rst_pc", pc, 32'd0);
    sync_model();
    mon_on = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 200 && n_ret < 8; c++) step(1'b1, 1'b1);
    check("directed_retires", 32'(n_ret), 32'd8);
    check("add_r3", rf[3], 32'd16);
    check("sub_r4", rf[4], 32'hFFFF_FFFE);
    check("load_r5", rf[5], 32'h0000_00AB);
    check("addi_r6", rf[6], 32'd5);
    check("store_mem", mem[63], 32'h0000_00AB);
    // reset while a LOAD waits in MEM
    mon_on = 1'b0; held = 1'b0; pend = 1'b0;
    rst_n = 1'b0;
    #1;
    mem[0] = enc(6'd4, 3'd7, 3'd0, 16'h0008);
    mem[2] = 32'h0000_1234;
    rf[0] = 32'd0;
    rf[7] = 32'h55;
    @(posedge clk);
    #1 rst_n = 1'b1; en = 1'b1; mem_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("memwait_req", 32'(mem_req), 32'd1);
    check("memwait_addr", mem_addr, 32'd8);
    check("memwait_we", 32'(mem_we), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_mem_req", 32'(mem_req), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_pc", pc, 32'd0);
    check("midrst_mem_addr", mem_addr, 32'd0);
    check("midrst_rf_we", 32'(rf_we), 32'd0);
    check("midrst_retire", 32'(retire), 32'd0);
    @(posedge clk);
    #1 check("midrst_no_write", rf[7], 32'h55);
    for (int i = 0; i < 256; i++) mem[i] = rand_instr();
    for (int i = 0; i < 8; i++) rf[i] = $urandom;
    sync_model();
    rst_n = 1'b1; en = 1'b1; mem_ready = 1'b0;
    @(posedge clk);
    #1 mem_ready = 1'($urandom_range(0, 1));
    mon_on = 1'b1;
    @(negedge clk);
    check("restart_req", 32'(mem_req), 32'd1);
    check("restart_addr", mem_addr, 32'd0);
    mon();
    @(posedge clk);
    #1;
    for (int c = 0; c < 4000; c++) step($urandom_range(0, 7) != 0, $urandom_range(0, 2) != 0);
    check("random_progress", 32'(n_ret > 200), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
